// File: rtl/wb_spi_slave.sv
// wb_spi_slave: Wishbone-attached SPI mode-0 responder with a one-byte RX
// buffer, a one-byte TX buffer, sticky error flags and a level interrupt.
// SPI pins are asynchronous and are synchronised into clk before edge
// detection; all SPI timing is derived from the detected SCK edges.
module wb_spi_slave #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   output logic        wb_ack_o,
   input  logic        spi_sck,
   input  logic        spi_mosi,
   input  logic        spi_cs_n,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   output logic        intr
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

   localparam logic [1:0] REG_RXDATA = 2'd0;
   localparam logic [1:0] REG_TXDATA = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   // synchroniser and edge detection
   logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q;
   logic                   sck_prev_q, cs_prev_q;
   logic                   sck_s, mosi_s, cs_s;
   logic                   sck_rise, sck_fall, cs_fall, cs_rise;

   // byte engine
   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  shift_tx_q, shift_tx_d;
   logic        miso_q, miso_d;
   logic        byte_start, byte_done;

   // register file
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_full_q, rx_full_d;
   logic [7:0]  tx_buf_q, tx_buf_d;
   logic        tx_full_q, tx_full_d;
   logic        overrun_q, overrun_d;
   logic        underrun_q, underrun_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] dat_q, dat_d;
   logic        ack_q;
   logic        intr_q, intr_d;
   logic        miso_oe_q;

   // bus decode
   logic        wb_req, acc_rd, acc_wr;
   logic [1:0]  reg_sel;
   logic        rd_rx, wr_tx, wr_status, wr_ctrl;
   logic [31:0] rd_mux;

   // Address bits outside [3:2], the byte selects and the upper data bits
   // carry no meaning for this block.
   logic unused_bits;
   assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign cs_fall  = ~cs_s & cs_prev_q;
   assign cs_rise  = cs_s & ~cs_prev_q;

   // Bring the SPI pins into clk and keep one delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '1;   // deselected level, so leaving reset never looks like a select
         sck_prev_q  <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
         sck_prev_q  <= sck_s;
         cs_prev_q   <= cs_s;
      end
   end

   // Byte engine state and shift registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         rx_shift_q <= 8'h00;
         shift_tx_q <= 8'h00;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_shift_d;
         shift_tx_q <= shift_tx_d;
         miso_q     <= miso_d;
      end
   end

   // Byte engine next state: sample on SCK rise, shift out on SCK fall, and
   // treat a fall with the counter at zero as the start of the next byte.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      shift_tx_d = shift_tx_q;
      miso_d     = miso_q;
      byte_start = 1'b0;
      byte_done  = 1'b0;
      if (cs_rise) begin
         // deselect abandons any partial byte
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) state_d = ST_LOAD;
            end
            ST_LOAD: begin
               byte_start = 1'b1;
               bit_cnt_d  = 3'd0;
               state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (sck_rise) begin
                  rx_shift_d = {rx_shift_q[6:0], mosi_s};
                  if (bit_cnt_q == 3'd7) begin
                     byte_done = 1'b1;
                     bit_cnt_d = 3'd0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end else if (sck_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     byte_start = 1'b1;
                  end else begin
                     shift_tx_d = {shift_tx_q[6:0], 1'b0};
                     miso_d     = shift_tx_q[6];
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      if (byte_start) begin
         // the old buffer content is taken even if the bus writes it this cycle
         shift_tx_d = tx_full_q ? tx_buf_q : IDLE_BYTE;
         miso_d     = shift_tx_d[7];
      end
   end

   // Bus decode and register next state; event sets take priority over
   // clears so a flag is never lost to a coincident W1C or pop.
   always_comb begin
      wb_req    = wb_stb_i & wb_cyc_i & ~ack_q;
      acc_rd    = wb_req & ~wb_we_i;
      acc_wr    = wb_req & wb_we_i;
      reg_sel   = wb_adr_i[3:2];
      rd_rx     = acc_rd & (reg_sel == REG_RXDATA);
      wr_tx     = acc_wr & (reg_sel == REG_TXDATA);
      wr_status = acc_wr & (reg_sel == REG_STATUS);
      wr_ctrl   = acc_wr & (reg_sel == REG_CTRL);

      rx_data_d = byte_done ? rx_shift_d : rx_data_q;
      if (byte_done)  rx_full_d = 1'b1;
      else if (rd_rx) rx_full_d = 1'b0;
      else            rx_full_d = rx_full_q;

      if (byte_done & rx_full_q & ~rd_rx) overrun_d = 1'b1;
      else if (wr_status & wb_dat_i[2])   overrun_d = 1'b0;
      else                                overrun_d = overrun_q;

      if (byte_start & ~tx_full_q)       underrun_d = 1'b1;
      else if (wr_status & wb_dat_i[3])  underrun_d = 1'b0;
      else                               underrun_d = underrun_q;

      tx_buf_d  = tx_buf_q;
      tx_full_d = tx_full_q;
      if (wr_tx) begin
         tx_buf_d  = wb_dat_i[7:0];
         tx_full_d = 1'b1;
      end else if (byte_start & tx_full_q) begin
         tx_full_d = 1'b0;
      end

      ctrl_d = wr_ctrl ? wb_dat_i[2:0] : ctrl_q;

      case (reg_sel)
         REG_RXDATA: rd_mux = {24'h0, rx_data_q};
         REG_STATUS: rd_mux = {27'h0, ~cs_s, underrun_q, overrun_q, ~tx_full_q, rx_full_q};
         REG_CTRL:   rd_mux = {29'h0, ctrl_q};
         default:    rd_mux = 32'h0;
      endcase
      dat_d = acc_rd ? rd_mux : 32'h0;

      intr_d = (ctrl_q[0] & rx_full_q) | (ctrl_q[1] & ~tx_full_q) |
               (ctrl_q[2] & (overrun_q | underrun_q));
   end

   // Register file, bus handshake and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_data_q  <= 8'h00;
         rx_full_q  <= 1'b0;
         tx_buf_q   <= 8'h00;
         tx_full_q  <= 1'b0;
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
         ctrl_q     <= 3'd0;
         dat_q      <= 32'h0;
         ack_q      <= 1'b0;
         intr_q     <= 1'b0;
         miso_oe_q  <= 1'b0;
      end else begin
         rx_data_q  <= rx_data_d;
         rx_full_q  <= rx_full_d;
         tx_buf_q   <= tx_buf_d;
         tx_full_q  <= tx_full_d;
         overrun_q  <= overrun_d;
         underrun_q <= underrun_d;
         ctrl_q     <= ctrl_d;
         dat_q      <= dat_d;
         ack_q      <= wb_req;
         intr_q     <= intr_d;
         miso_oe_q  <= ~cs_s;
      end
   end

   assign wb_dat_o    = dat_q;
   assign wb_ack_o    = ack_q;
   assign spi_miso    = miso_q;
   assign spi_miso_oe = miso_oe_q;
   assign intr        = intr_q;

endmodule

// File: tb/tb_wb_spi_slave.sv
// tb_wb_spi_slave: directed bench for wb_spi_slave. A transaction-level model
// of the register file tracks what the block must hold; a compare process
// checks bus read data, interrupt and output-enable against it, and literal
// expectations pin the model at key points.
module tb_wb_spi_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
   logic        spi_sck, spi_mosi, spi_cs_n, spi_miso, spi_miso_oe, intr;

   wb_spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
      .clk(clk), .rst(rst),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
      .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
      .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .intr(intr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // model state
   logic [7:0]  m_rx, m_tx_buf, m_cur_tx;
   logic        m_rx_full, m_tx_full, m_ovr, m_udr, m_sel;
   logic [2:0]  m_ctrl;

   bit          settled = 1'b0;
   bit          rd_pending = 1'b0;
   logic [31:0] rd_exp;
   bit          ack_prev = 1'b0;
   logic [31:0] q;
   logic [7:0]  mi;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_rx = 8'h00; m_tx_buf = 8'h00; m_cur_tx = 8'h00;
      m_rx_full = 1'b0; m_tx_full = 1'b0; m_ovr = 1'b0; m_udr = 1'b0;
      m_sel = 1'b0; m_ctrl = 3'd0;
   endfunction

   function automatic void model_byte_start();
      if (m_tx_full) begin
         m_cur_tx  = m_tx_buf;
         m_tx_full = 1'b0;
      end else begin
         m_cur_tx = 8'hFF;
         m_udr    = 1'b1;
      end
   endfunction

   function automatic void model_byte_done(input logic [7:0] b);
      if (m_rx_full) m_ovr = 1'b1;
      m_rx      = b;
      m_rx_full = 1'b1;
   endfunction

   function automatic logic [31:0] model_read(input logic [3:0] off);
      case (off)
         4'h0:    return {24'h0, m_rx};
         4'h8:    return {27'h0, m_sel, m_udr, m_ovr, ~m_tx_full, m_rx_full};
         4'hC:    return {29'h0, m_ctrl};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic model_intr();
      return (m_ctrl[0] & m_rx_full) | (m_ctrl[1] & ~m_tx_full) | (m_ctrl[2] & (m_ovr | m_udr));
   endfunction

   // Compare process: reset values, read data on ack, single-cycle ack, and
   // interrupt / output enable whenever the bench is between events.
   always @(negedge clk) begin
      if (!rst) begin
         check("reset_outputs", {wb_dat_o, wb_ack_o, spi_miso, spi_miso_oe, intr}, 64'h0);
      end else begin
         if (wb_ack_o) begin
            check("ack_single_cycle", ack_prev, 1'b0);
            if (rd_pending) check("read_data", wb_dat_o, rd_exp);
         end
         if (settled) begin
            check("intr", intr, model_intr());
            check("miso_oe", spi_miso_oe, m_sel);
         end
      end
      ack_prev = wb_ack_o;
   end

   task automatic half();
      repeat (6) @(posedge clk);
      #2;
   endtask

   task automatic wb_access(input bit we, input logic [3:0] off, input logic [31:0] d,
                            output logic [31:0] rd);
      int n;
      @(posedge clk);
      #1;
      wb_adr_i = {28'h0, off};
      wb_dat_i = d;
      wb_we_i  = we;
      wb_sel_i = 4'hF;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wb_ack_o && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("ack_arrives", wb_ack_o, 1'b1);
      rd = wb_dat_o;
      @(posedge clk);
      #1;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic wb_rd(input logic [3:0] off, output logic [31:0] rd);
      settled    = 1'b0;
      rd_exp     = model_read(off);
      rd_pending = 1'b1;
      wb_access(1'b0, off, 32'h0, rd);
      rd_pending = 1'b0;
      if (off == 4'h0) m_rx_full = 1'b0;
      repeat (3) @(posedge clk);
      settled = 1'b1;
   endtask

   task automatic wb_wr(input logic [3:0] off, input logic [31:0] d);
      logic [31:0] dummy;
      settled = 1'b0;
      wb_access(1'b1, off, d, dummy);
      case (off)
         4'h4: begin m_tx_buf = d[7:0]; m_tx_full = 1'b1; end
         4'h8: begin if (d[2]) m_ovr = 1'b0; if (d[3]) m_udr = 1'b0; end
         4'hC: m_ctrl = d[2:0];
         default: ;
      endcase
      repeat (3) @(posedge clk);
      settled = 1'b1;
   endtask

   task automatic cs_low();
      settled  = 1'b0;
      spi_cs_n = 1'b0;
      m_sel    = 1'b1;
      model_byte_start();
      repeat (8) @(posedge clk);
      #2;
      settled = 1'b1;
   endtask

   task automatic cs_high();
      settled  = 1'b0;
      spi_cs_n = 1'b1;
      m_sel    = 1'b0;
      half();
      if (spi_sck) begin
         spi_sck = 1'b0;
         half();
      end
      settled = 1'b1;
   endtask

   // Master side: drive nbits MSB first, capture MISO at each rising edge.
   // With hold set, SCK is left high after the last rising edge.
   task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit hold,
                           output logic [7:0] mi_o);
      logic [7:0] cap = 8'h00;
      settled = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = mo[7-i];
         half();
         spi_sck    = 1'b1;
         cap[7-i]   = spi_miso;
         if (!(hold && i == nbits - 1)) begin
            half();
            spi_sck = 1'b0;
         end
      end
      if (nbits == 8) begin
         check("miso_byte", cap, m_cur_tx);
         model_byte_done(mo);
         if (!hold) model_byte_start();
      end
      half();
      mi_o    = cap;
      settled = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
      wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'h0;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
      model_reset();
      #3 rst = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_outputs", {wb_dat_o, wb_ack_o, spi_miso, spi_miso_oe, intr}, 64'h0);
      settled = 1'b1;
      wb_rd(4'h8, q); check("status_reset", q, 32'h02);

      // TX A5 while receiving 3C
      wb_wr(4'h4, 32'hA5);
      cs_low();
      spi_byte(8'h3C, 8, 1'b1, mi); check("miso_a5", mi, 8'hA5);
      wb_rd(4'h8, q); check("status_13", q, 32'h13);
      wb_rd(4'h0, q); check("rxdata_3c", q, 32'h3C);
      wb_rd(4'h8, q); check("status_12", q, 32'h12);
      wb_rd(4'h4, q); check("txdata_reads_0", q, 32'h0);
      cs_high();

      // back-to-back bytes without a read: overrun
      cs_low();
      spi_byte(8'h11, 8, 1'b0, mi); check("miso_idle_1", mi, 8'hFF);
      spi_byte(8'h22, 8, 1'b1, mi);
      wb_rd(4'h8, q); check("status_1f", q, 32'h1F);
      wb_wr(4'h8, 32'h4);
      wb_rd(4'h8, q); check("status_1b", q, 32'h1B);
      cs_high();
      wb_rd(4'h0, q); check("rxdata_22", q, 32'h22);

      // underrun interrupt
      wb_wr(4'h8, 32'hC);
      wb_wr(4'hC, 32'h4);
      @(negedge clk); check("intr_off", intr, 1'b0);
      cs_low();
      spi_byte(8'h00, 8, 1'b1, mi); check("miso_ff", mi, 8'hFF);
      cs_high();
      @(negedge clk); check("intr_underrun", intr, 1'b1);
      wb_wr(4'h8, 32'h8);
      @(negedge clk); check("intr_cleared", intr, 1'b0);

      // deselect after 5 bits, then a clean byte
      cs_low();
      spi_byte(8'hFF, 5, 1'b0, mi);
      cs_high();
      wb_rd(4'h8, q); check("status_partial", q, 32'h0B);
      wb_rd(4'h0, q); check("rxdata_00", q, 32'h00);
      wb_wr(4'h8, 32'h8);
      wb_wr(4'h4, 32'hC3);
      cs_low();
      spi_byte(8'h5A, 8, 1'b1, mi); check("miso_c3", mi, 8'hC3);
      cs_high();
      wb_rd(4'h0, q); check("rxdata_5a", q, 32'h5A);
      wb_rd(4'h8, q); check("status_after_5a", q, 32'h02);

      // RXDATA read landing on the same cycle as byte completion
      wb_wr(4'hC, 32'h2);
      cs_low();
      spi_byte(8'h77, 8, 1'b0, mi);
      spi_byte(8'h88, 7, 1'b0, mi);
      settled  = 1'b0;
      spi_mosi = 1'b0;
      half();
      spi_sck = 1'b1;
      @(posedge clk);
      rd_exp     = model_read(4'h0);
      rd_pending = 1'b1;
      wb_access(1'b0, 4'h0, 32'h0, q);
      rd_pending = 1'b0;
      check("read_coincide", q, 32'h77);
      m_rx      = 8'h88;
      m_rx_full = 1'b1;
      half();
      spi_sck = 1'b0;
      model_byte_start();
      half();
      settled = 1'b1;
      wb_rd(4'h8, q); check("status_coincide", q, 32'h1B);
      wb_rd(4'h0, q); check("rxdata_88", q, 32'h88);

      // asynchronous reset mid-byte
      spi_byte(8'hF0, 3, 1'b0, mi);
      @(negedge clk);
      check("oe_before_rst", spi_miso_oe, 1'b1);
      check("intr_before_rst", intr, 1'b1);
      #3;
      settled = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_async_outputs", {wb_dat_o, wb_ack_o, spi_miso, spi_miso_oe, intr}, 64'h0);
      spi_cs_n = 1'b1;
      spi_sck  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      settled = 1'b1;
      wb_rd(4'h8, q); check("status_after_rst", q, 32'h02);
      wb_rd(4'hC, q); check("ctrl_after_rst", q, 32'h0);
      wb_rd(4'h0, q); check("rxdata_after_rst", q, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
